dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter s, default 32, data/address width in bits.
REQ-002 Parameter DEPTH, default 32, number of valid data-memory words; legal addresses are 0..DEPTH-1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 a_req / b_req  in  1  requester A (core load/store) / B (debug/DMA) access request.
REQ-006 a_we / b_we  in  1  1 = write, 0 = read.
REQ-007 a_addr / b_addr  in  s  word address.
REQ-008 a_wdata / b_wdata  in  s  write data.
REQ-009 a_gnt / b_gnt  out  1  one-cycle pulse: request accepted, memory strobed this cycle.
REQ-010 a_rvalid / b_rvalid  out  1  one-cycle completion pulse (reads and writes).
REQ-011 a_rdata / b_rdata  out  s  read data, valid when the matching rvalid is 1.
REQ-012 a_err / b_err  out  1  out-of-range address flag, valid with rvalid.
REQ-013 mem_read  out  1  data-memory read strobe.
REQ-014 mem_write  out  1  data-memory write strobe.
REQ-015 mem_addr  out  s  data-memory address.
REQ-016 mem_wdata  out  s  data-memory write data (drives the memory's data_in_rs2).
REQ-017 mem_rdata  in  s  combinational read data from data memory.

Function
REQ-018 FSM states IDLE, ACCESS, RESP, all registered; one access occupies exactly one ACCESS cycle followed by one RESP cycle.
REQ-019 IDLE: if any req = 1, arbitrate, capture winner's we/addr/wdata into internal registers, go to ACCESS; else stay in IDLE.
REQ-020 Arbitration: single requester wins; if both request, the requester not granted last wins (round-robin); last_gnt updates on every grant.
REQ-021 ACCESS: winner's gnt = 1; mem_addr and mem_wdata driven from captured registers; mem_read = !we and mem_write = we when addr < DEPTH, else both 0.
REQ-022 mem_read and mem_write are never 1 simultaneously and are 0 in every state except ACCESS.
REQ-023 ACCESS to RESP unconditionally; on that edge, register mem_rdata for in-range reads, 0 for writes and out-of-range accesses.
REQ-024 RESP: winner's rvalid = 1, rdata = registered value, err = 1 iff captured addr >= DEPTH; the other requester's rvalid/err = 0.
REQ-025 RESP: if any req = 1, arbitrate as in IDLE and go directly to ACCESS; else go to IDLE.
REQ-026 Latency: req sampled at edge k gives gnt in cycle k+1 and rvalid in cycle k+2; sustained throughput is one access per 2 cycles.
REQ-027 Requesters hold req, we, addr and wdata stable until gnt, then deassert req in the gnt cycle unless issuing a new request.
REQ-028 A requester with req = 1 during its own RESP cycle is treated as a new request.
REQ-029 Address comparison is unsigned, over the full s bits; no address wrap or truncation.
REQ-030 With both requesters continuously requesting, grants alternate A, B, A, B, so no requester waits more than one access.
REQ-031 gnt, rvalid, rdata and err are 0 outside the cycles defined above.

Reset
REQ-032 reset = 1 at a rising edge forces IDLE, last_gnt = B (A wins the first tie), and all captured registers to 0.
REQ-033 After reset, all outputs (gnt, rvalid, rdata, err, mem_read, mem_write, mem_addr, mem_wdata) are 0.
REQ-034 Strobes already driven in the cycle reset is sampled remain as registered; reset during ACCESS or RESP aborts the transaction with no rvalid issued.
REQ-035 Requests present while reset = 1 are ignored and must be re-presented after reset.

Verification
REQ-036 A write 0xDEADBEEF to addr 5, then A read addr 5 -> mem_write=1 in write gnt cycle; read rvalid 2 cycles after req with a_rdata=0xDEADBEEF, a_err=0.
REQ-037 A and B both request continuously from reset -> gnt sequence A,B,A,B at cycles 1,3,5,7; each rvalid one cycle after its gnt.
REQ-038 B read addr 32 (DEPTH=32) -> b_gnt pulses with mem_read=mem_write=0; next cycle b_rvalid=1, b_err=1, b_rdata=0.
REQ-039 A write in flight, reset asserted in ACCESS cycle -> next cycle IDLE, all outputs 0, no a_rvalid; first post-reset tie grants A.
REQ-040 Back-to-back A reads addr 1 then addr 2 with req held high in RESP -> ACCESS directly follows RESP, no IDLE cycle; rdata matches stored words.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port data memory.
// One access takes one ACCESS cycle (gnt + memory strobe), then one RESP cycle
// (rvalid + rdata/err). A request seen in IDLE or RESP is granted on the next cycle.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     requester A (core load/store)
//   b_req/b_we/b_addr/b_wdata     requester B (debug/DMA)
//   a_gnt/b_gnt                   request accepted, memory strobed this cycle
//   a_rvalid/b_rvalid             completion pulse, with a_rdata/b_rdata and a_err/b_err
//   mem_read/mem_write            data-memory strobes (never both high)
//   mem_addr/mem_wdata            data-memory address / write data
//   mem_rdata                     combinational read data from data memory
module dmem_arbiter #(
    parameter int unsigned s     = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_req,
    input  logic         a_we,
    input  logic [s-1:0] a_addr,
    input  logic [s-1:0] a_wdata,
    input  logic         b_req,
    input  logic         b_we,
    input  logic [s-1:0] b_addr,
    input  logic [s-1:0] b_wdata,
    output logic         a_gnt,
    output logic         a_rvalid,
    output logic [s-1:0] a_rdata,
    output logic         a_err,
    output logic         b_gnt,
    output logic         b_rvalid,
    output logic [s-1:0] b_rdata,
    output logic         b_err,
    output logic         mem_read,
    output logic         mem_write,
    output logic [s-1:0] mem_addr,
    output logic [s-1:0] mem_wdata,
    input  logic [s-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [s-1:0] DEPTH_W = s'(DEPTH);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         last_b;       // 1 = B was granted most recently
    logic         last_b_nxt;
    logic         cap_b;        // captured winner: 1 = B, 0 = A
    logic         cap_b_nxt;
    logic         cap_we;
    logic         cap_we_nxt;
    logic [s-1:0] cap_addr;
    logic [s-1:0] cap_addr_nxt;
    logic [s-1:0] cap_wdata;
    logic [s-1:0] cap_wdata_nxt;

    logic         win_b;
    logic         go_access;
    logic         go_resp;
    logic         in_range_nxt;
    logic         in_range_cur;
    logic [s-1:0] rd_sel;

    logic         a_gnt_d;
    logic         b_gnt_d;
    logic         a_rvalid_d;
    logic         b_rvalid_d;
    logic [s-1:0] a_rdata_d;
    logic [s-1:0] b_rdata_d;
    logic         a_err_d;
    logic         b_err_d;
    logic         mem_read_d;
    logic         mem_write_d;
    logic [s-1:0] mem_addr_d;
    logic [s-1:0] mem_wdata_d;

    // State and captured-request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            cap_b     <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state     <= state_nxt;
            last_b    <= last_b_nxt;
            cap_b     <= cap_b_nxt;
            cap_we    <= cap_we_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_wdata <= cap_wdata_nxt;
        end
    end

    // Next state, round-robin arbitration and request capture
    always_comb begin
        state_nxt     = state;
        last_b_nxt    = last_b;
        cap_b_nxt     = cap_b;
        cap_we_nxt    = cap_we;
        cap_addr_nxt  = cap_addr;
        cap_wdata_nxt = cap_wdata;

        // On a tie the requester not granted last wins.
        win_b = b_req & (~a_req | ~last_b);

        case (state)
            IDLE, RESP: begin
                if (a_req | b_req) begin
                    state_nxt     = ACCESS;
                    last_b_nxt    = win_b;
                    cap_b_nxt     = win_b;
                    cap_we_nxt    = win_b ? b_we    : a_we;
                    cap_addr_nxt  = win_b ? b_addr  : a_addr;
                    cap_wdata_nxt = win_b ? b_wdata : a_wdata;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        go_access    = (state_nxt == ACCESS);
        go_resp      = (state == ACCESS);
        in_range_nxt = (cap_addr_nxt < DEPTH_W);
        in_range_cur = (cap_addr < DEPTH_W);

        a_gnt_d     = go_access & ~cap_b_nxt;
        b_gnt_d     = go_access &  cap_b_nxt;
        mem_read_d  = go_access & ~cap_we_nxt & in_range_nxt;
        mem_write_d = go_access &  cap_we_nxt & in_range_nxt;
        mem_addr_d  = go_access ? cap_addr_nxt  : '0;
        mem_wdata_d = go_access ? cap_wdata_nxt : '0;

        // Writes and out-of-range accesses return zero data.
        rd_sel = (go_resp & ~cap_we & in_range_cur) ? mem_rdata : '0;

        a_rvalid_d = go_resp & ~cap_b;
        b_rvalid_d = go_resp &  cap_b;
        a_rdata_d  = a_rvalid_d ? rd_sel : '0;
        b_rdata_d  = b_rvalid_d ? rd_sel : '0;
        a_err_d    = a_rvalid_d & ~in_range_cur;
        b_err_d    = b_rvalid_d & ~in_range_cur;
    end

    // Registered outputs; reset clears them so an in-flight access never completes
    always_ff @(posedge clk) begin
        if (reset) begin
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            a_gnt     <= a_gnt_d;
            b_gnt     <= b_gnt_d;
            a_rvalid  <= a_rvalid_d;
            b_rvalid  <= b_rvalid_d;
            a_rdata   <= a_rdata_d;
            b_rdata   <= b_rdata_d;
            a_err     <= a_err_d;
            b_err     <= b_err_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random two-requester traffic against a transaction-level
// reference (grant schedule, round-robin winner, reference memory image).
module tb_dmem_arbiter;

    localparam int unsigned S     = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [1:0]   we;
    logic [S-1:0] addr  [2];
    logic [S-1:0] wdata [2];

    logic         a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
    logic [S-1:0] a_rdata, b_rdata;
    logic         mem_read, mem_write;
    logic [S-1:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.s(S), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (req[0]),
        .a_we     (we[0]),
        .a_addr   (addr[0]),
        .a_wdata  (wdata[0]),
        .b_req    (req[1]),
        .b_we     (we[1]),
        .b_addr   (addr[1]),
        .b_wdata  (wdata[1]),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .a_err    (a_err),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .b_err    (b_err),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Environment data memory: combinational read, write on rising edge.
    logic [S-1:0] dmem [DEPTH];
    always_comb begin
        if (mem_addr < S'(DEPTH)) mem_rdata = dmem[mem_addr[AW-1:0]];
        else                      mem_rdata = 32'hBAD0_0BAD;
    end
    always @(posedge clk) begin
        if (mem_write && mem_addr < S'(DEPTH)) dmem[mem_addr[AW-1:0]] <= mem_wdata;
    end

    // Reference image of memory contents
    logic [S-1:0] ref_mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs for the current cycle
    logic [1:0]   exp_gnt, exp_rv, exp_err;
    logic [S-1:0] exp_rd [2];
    logic         exp_after_rst;
    // Transaction granted in the current cycle
    logic         t_who, t_we;
    logic [S-1:0] t_addr, t_wdata;
    logic         last_who;     // requester granted most recently (1 = B)
    int           mode;         // 0 = random traffic, 1 = both always requesting

    task automatic new_txn(input int i);
        int r;
        r = int'($urandom % 8);
        we[i] = 1'($urandom % 2);
        if (r == 0)      addr[i] = 32'h8000_0000 | S'($urandom_range(0, DEPTH - 1));
        else if (r == 1) addr[i] = S'(DEPTH) + S'($urandom % 4);
        else             addr[i] = S'($urandom_range(0, DEPTH - 1));
        wdata[i] = $urandom;
        req[i]   = 1'b1;
    endtask

    task automatic check_cycle();
        check("a_gnt",    64'(a_gnt),    64'(exp_gnt[0]));
        check("b_gnt",    64'(b_gnt),    64'(exp_gnt[1]));
        check("a_rvalid", 64'(a_rvalid), 64'(exp_rv[0]));
        check("b_rvalid", 64'(b_rvalid), 64'(exp_rv[1]));
        check("a_rdata",  64'(a_rdata),  64'(exp_rd[0]));
        check("b_rdata",  64'(b_rdata),  64'(exp_rd[1]));
        check("a_err",    64'(a_err),    64'(exp_err[0]));
        check("b_err",    64'(b_err),    64'(exp_err[1]));
        if (exp_gnt != 2'b00) begin
            check("mem_read",  64'(mem_read),  64'(!t_we && t_addr < S'(DEPTH)));
            check("mem_write", 64'(mem_write), 64'(t_we && t_addr < S'(DEPTH)));
            check("mem_addr",  64'(mem_addr),  64'(t_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
        end else begin
            check("mem_read",  64'(mem_read),  64'(0));
            check("mem_write", 64'(mem_write), 64'(0));
        end
        if (exp_after_rst) begin
            check("rst_mem_addr",  64'(mem_addr),  64'(0));
            check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        end
    endtask

    // Advance the reference by one clock edge using the inputs now presented.
    task automatic model_step();
        logic [1:0]   n_gnt, n_rv, n_err;
        logic [S-1:0] n_rd [2];
        logic         in_rng, w;
        n_gnt = '0; n_rv = '0; n_err = '0;
        n_rd[0] = '0; n_rd[1] = '0;
        if (exp_gnt != 2'b00) begin
            // Access ends this edge: the memory strobe is already out, reset or not.
            in_rng = (t_addr < S'(DEPTH));
            if (!reset) begin
                n_rv[t_who]  = 1'b1;
                n_err[t_who] = !in_rng;
                n_rd[t_who]  = (!t_we && in_rng) ? ref_mem[t_addr[AW-1:0]] : '0;
            end
            if (t_we && in_rng) ref_mem[t_addr[AW-1:0]] = t_wdata;
        end else if (!reset && req != 2'b00) begin
            w        = (req == 2'b11) ? !last_who : req[1];
            last_who = w;
            t_who    = w;
            t_we     = we[w];
            t_addr   = addr[w];
            t_wdata  = wdata[w];
            n_gnt[w] = 1'b1;
        end
        if (reset) last_who = 1'b1;
        exp_after_rst = reset;
        exp_gnt = n_gnt; exp_rv = n_rv; exp_err = n_err;
        exp_rd[0] = n_rd[0]; exp_rd[1] = n_rd[1];
    endtask

    // Requesters: hold until granted, then maybe issue a new request at once.
    task automatic agents_step();
        logic [1:0] g;
        g = {b_gnt, a_gnt};
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (req[i] && g[i]) begin
                if (mode == 1 || ($urandom % 3) == 0) new_txn(i);
                else req[i] = 1'b0;
            end else if (!req[i] && (mode == 1 || ($urandom % 4) == 0)) begin
                new_txn(i);
            end
        end
        if (mode == 0 && ((($urandom % 150) == 0) || ((g != 2'b00) && ($urandom % 25) == 0)))
            reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        reset = 1'b1;
        req   = '0;
        we    = '0;
        addr[0] = '0; addr[1] = '0;
        wdata[0] = '0; wdata[1] = '0;
        mode = 0;
        exp_gnt = '0; exp_rv = '0; exp_err = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        exp_after_rst = 1'b1;
        t_who = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
        last_who = 1'b1;
        repeat (2) @(posedge clk);

        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_cycle();
            model_step();
            @(posedge clk);
            #1;
            agents_step();
            // Phase with both requesters continuously busy, starting from reset.
            if (cyc == 1500) begin
                mode  = 1;
                reset = 1'b1;
                new_txn(0);
                new_txn(1);
            end
            if (cyc == 1560) mode = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
